// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic controller.
// Lamp codes, one-hot states, phase indices and sequence helper.
package traffic_pkg;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_RED = 3'b001;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b100;

    typedef enum logic [6:0] {
        ST_IDLE  = 7'b0000001,
        ST_R1Y   = 7'b0000010,
        ST_R1G   = 7'b0000100,
        ST_BOTHY = 7'b0001000,
        ST_R2G   = 7'b0010000,
        ST_R2Y   = 7'b0100000,
        ST_FLASH = 7'b1000000
    } state_e;

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_R1Y   = 3'd1;
    localparam logic [2:0] PH_R1G   = 3'd2;
    localparam logic [2:0] PH_BOTHY = 3'd3;
    localparam logic [2:0] PH_R2G   = 3'd4;
    localparam logic [2:0] PH_R2Y   = 3'd5;
    localparam logic [2:0] PH_FLASH = 3'd6;

    typedef struct packed {
        logic [2:0] road1;
        logic [2:0] road2;
        logic [2:0] ped1;
        logic [2:0] ped2;
    } lamps_t;

    function automatic state_e seq_next(input state_e s);
        unique case (s)
            ST_R1Y:   seq_next = ST_R1G;
            ST_R1G:   seq_next = ST_BOTHY;
            ST_BOTHY: seq_next = ST_R2G;
            ST_R2G:   seq_next = ST_R2Y;
            default:  seq_next = ST_R1Y;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter for the timed traffic states.
// Counts 0..term; done when term reached and not held.
module phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             hold,
    input  logic [CNT_W-1:0] term,
    output logic             done
);

    logic [CNT_W-1:0] count;

    assign done = (count == term) && !hold;

    // Clear outside timed states and at each boundary, freeze on hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr || done) begin
            count <= '0;
        end else if (!hold) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_ctrl_gen.sv
// Two-road traffic controller with parametrised phase timing.
// Supports hold, end-of-cycle stop and night flashing mode.
module traffic_ctrl_gen #(
    parameter int CNT_W      = 6,
    parameter int T_Y1       = 5,
    parameter int T_G1       = 5,
    parameter int T_YY       = 2,
    parameter int T_G2       = 5,
    parameter int T_Y2       = 5,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       hold,
    input  logic       night_mode,
    output logic       enable_sig,
    output logic [2:0] road1_out,
    output logic [2:0] road2_out,
    output logic [2:0] ped1,
    output logic [2:0] ped2,
    output logic [2:0] phase,
    output logic       phase_done
);

    import traffic_pkg::*;

    localparam int TMAX = 2 ** CNT_W;
    localparam int FW   = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    localparam logic [CNT_W-1:0] TM_Y1 = CNT_W'(T_Y1 - 1);
    localparam logic [CNT_W-1:0] TM_G1 = CNT_W'(T_G1 - 1);
    localparam logic [CNT_W-1:0] TM_YY = CNT_W'(T_YY - 1);
    localparam logic [CNT_W-1:0] TM_G2 = CNT_W'(T_G2 - 1);
    localparam logic [CNT_W-1:0] TM_Y2 = CNT_W'(T_Y2 - 1);
    localparam logic [FW-1:0]    FH_TM = FW'(FLASH_HALF - 1);

    if (CNT_W < 1 || CNT_W > 30) begin : g_chk_w
        $error("traffic_ctrl_gen: CNT_W out of range");
    end
    if (T_Y1 < 1 || T_Y1 > TMAX || T_G1 < 1 || T_G1 > TMAX ||
        T_YY < 1 || T_YY > TMAX || T_G2 < 1 || T_G2 > TMAX ||
        T_Y2 < 1 || T_Y2 > TMAX) begin : g_chk_t
        $error("traffic_ctrl_gen: phase time out of range");
    end
    if (FLASH_HALF < 1) begin : g_chk_f
        $error("traffic_ctrl_gen: FLASH_HALF must be >= 1");
    end

    state_e           state;
    logic             timed;
    logic             t_done;
    logic             boundary;
    logic [CNT_W-1:0] term;
    logic [FW-1:0]    fcnt;
    logic             fbit;
    lamps_t           lamps;

    assign timed    = |state[5:1];
    assign boundary = timed && t_done;

    // Select the terminal count of the current timed phase
    always_comb begin
        term = '0;
        unique case (state)
            ST_R1Y:   term = TM_Y1;
            ST_R1G:   term = TM_G1;
            ST_BOTHY: term = TM_YY;
            ST_R2G:   term = TM_G2;
            ST_R2Y:   term = TM_Y2;
            default:  term = '0;
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!timed),
        .hold  (hold),
        .term  (term),
        .done  (t_done)
    );

    // State sequencing, flash blinker and phase-change pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            phase_done <= 1'b0;
            fcnt       <= '0;
            fbit       <= 1'b1;
        end else begin
            phase_done <= boundary;
            if (state == ST_FLASH) begin
                if (fcnt == FH_TM) begin
                    fcnt <= '0;
                    fbit <= ~fbit;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end else begin
                fcnt <= '0;
                fbit <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (night_mode)  state <= ST_FLASH;
                    else if (enable) state <= ST_R1Y;
                end
                ST_FLASH: begin
                    if (!night_mode) state <= ST_R1Y;
                end
                default: begin
                    if (boundary) begin
                        if (night_mode)
                            state <= ST_FLASH;
                        else if (state == ST_R2Y && !enable)
                            state <= ST_IDLE;
                        else
                            state <= seq_next(state);
                    end
                end
            endcase
        end
    end

    // Moore decode of lamps, phase index and active flag
    always_comb begin
        lamps      = '{LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED};
        phase      = PH_IDLE;
        enable_sig = 1'b1;
        unique case (state)
            ST_R1Y: begin
                lamps = '{LAMP_YEL, LAMP_RED, LAMP_RED, LAMP_GRN};
                phase = PH_R1Y;
            end
            ST_R1G: begin
                lamps = '{LAMP_GRN, LAMP_RED, LAMP_RED, LAMP_GRN};
                phase = PH_R1G;
            end
            ST_BOTHY: begin
                lamps = '{LAMP_YEL, LAMP_YEL, LAMP_RED, LAMP_RED};
                phase = PH_BOTHY;
            end
            ST_R2G: begin
                lamps = '{LAMP_RED, LAMP_GRN, LAMP_GRN, LAMP_RED};
                phase = PH_R2G;
            end
            ST_R2Y: begin
                lamps = '{LAMP_RED, LAMP_YEL, LAMP_GRN, LAMP_RED};
                phase = PH_R2Y;
            end
            ST_FLASH: begin
                lamps.road1 = fbit ? LAMP_YEL : LAMP_OFF;
                lamps.road2 = fbit ? LAMP_YEL : LAMP_OFF;
                phase       = PH_FLASH;
            end
            default: begin
                enable_sig = 1'b0;
            end
        endcase
    end

    assign road1_out = lamps.road1;
    assign road2_out = lamps.road2;
    assign ped1      = lamps.ped1;
    assign ped2      = lamps.ped2;

endmodule

// File: tb/tb_traffic_ctrl_gen.sv
// Self-checking bench for traffic_ctrl_gen.
// Vector tables plus hand sequences, scored through a queue.
module tb_traffic_ctrl_gen;

    import traffic_pkg::*;

    typedef struct packed {
        logic [2:0] ph;
        logic       pd;
        logic       es;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [2:0] p1;
        logic [2:0] p2;
    } obs_t;

    typedef struct {
        logic en;
        logic hd;
        logic nt;
        obs_t exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;
    logic hd    = 1'b0;
    logic nt    = 1'b0;
    logic rst2_n = 1'b0;
    logic en2    = 1'b0;

    logic       es1, pd1, es2, pd2;
    logic [2:0] r1_1, r2_1, p1_1, p2_1, ph1;
    logic [2:0] r1_2, r2_2, p1_2, p2_2, ph2;
    obs_t       obs1, obs2;

    int checks = 0;
    int errors = 0;
    vec_t tab[$];
    obs_t sb[$];
    obs_t sb2[$];

    always #5 clk = ~clk;

    traffic_ctrl_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (en),
        .hold       (hd),
        .night_mode (nt),
        .enable_sig (es1),
        .road1_out  (r1_1),
        .road2_out  (r2_1),
        .ped1       (p1_1),
        .ped2       (p2_1),
        .phase      (ph1),
        .phase_done (pd1)
    );

    traffic_ctrl_gen #(
        .T_G1 (1),
        .T_YY (1)
    ) dut_short (
        .clk        (clk),
        .rst_n      (rst2_n),
        .enable     (en2),
        .hold       (1'b0),
        .night_mode (1'b0),
        .enable_sig (es2),
        .road1_out  (r1_2),
        .road2_out  (r2_2),
        .ped1       (p1_2),
        .ped2       (p2_2),
        .phase      (ph2),
        .phase_done (pd2)
    );

    assign obs1 = {ph1, pd1, es1, r1_1, r2_1, p1_1, p2_1};
    assign obs2 = {ph2, pd2, es2, r1_2, r2_2, p1_2, p2_2};

    function automatic obs_t mk(input logic [2:0] ph, input logic pd,
                                input logic fb);
        obs_t o;
        o.ph = ph;
        o.pd = pd;
        o.es = (ph != 3'd0);
        o.r1 = 3'b001; o.r2 = 3'b001; o.p1 = 3'b001; o.p2 = 3'b001;
        case (ph)
            3'd1: begin o.r1 = 3'b010; o.p2 = 3'b100; end
            3'd2: begin o.r1 = 3'b100; o.p2 = 3'b100; end
            3'd3: begin o.r1 = 3'b010; o.r2 = 3'b010; end
            3'd4: begin o.r2 = 3'b100; o.p1 = 3'b100; end
            3'd5: begin o.r2 = 3'b010; o.p1 = 3'b100; end
            3'd6: begin
                o.r1 = fb ? 3'b010 : 3'b000;
                o.r2 = fb ? 3'b010 : 3'b000;
            end
            default: ;
        endcase
        return o;
    endfunction

    task automatic check(input string name, input int idx,
                         input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got ph=%0d pd=%b es=%b lamps=%b_%b_%b_%b want ph=%0d pd=%b es=%b lamps=%b_%b_%b_%b",
                     name, idx, act.ph, act.pd, act.es, act.r1, act.r2,
                     act.p1, act.p2, exp.ph, exp.pd, exp.es, exp.r1,
                     exp.r2, exp.p1, exp.p2);
        end
    endtask

    task automatic add(input logic e, input logic h, input logic n,
                       input logic [2:0] ph, input int len,
                       input logic pd_first, input logic fb = 1'b1);
        for (int i = 0; i < len; i++) begin
            vec_t v;
            v.en  = e;
            v.hd  = h;
            v.nt  = n;
            v.exp = mk(ph, (i == 0) ? pd_first : 1'b0, fb);
            tab.push_back(v);
        end
    endtask

    task automatic run_tab(input string name);
        for (int i = 0; i < tab.size(); i++) begin
            en = tab[i].en;
            hd = tab[i].hd;
            nt = tab[i].nt;
            sb.push_back(tab[i].exp);
            @(posedge clk);
            #1;
            check(name, i, obs1, sb.pop_front());
        end
        tab.delete();
    endtask

    initial begin
        logic [2:0] ph_s[8];
        logic       pd_s[8];

        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, obs1, mk(3'd0, 1'b0, 1'b1));
        #2 rst_n = 1'b1;

        // full cycle 5/5/2/5/5 then wrap to R1Y
        add(1, 0, 0, 3'd1, 5, 0);
        add(1, 0, 0, 3'd2, 5, 1);
        add(1, 0, 0, 3'd3, 2, 1);
        add(1, 0, 0, 3'd4, 5, 1);
        add(1, 0, 0, 3'd5, 5, 1);
        run_tab("cycle");

        // hold three cycles at the last R1G count
        add(1, 0, 0, 3'd1, 5, 1);
        add(1, 0, 0, 3'd2, 5, 1);
        add(1, 1, 0, 3'd2, 3, 0);
        add(1, 0, 0, 3'd3, 2, 1);
        add(1, 0, 0, 3'd4, 5, 1);
        add(1, 0, 0, 3'd5, 5, 1);
        run_tab("hold");

        // enable dropped in R1G, cycle completes, then IDLE
        add(1, 0, 0, 3'd1, 5, 1);
        add(1, 0, 0, 3'd2, 1, 1);
        add(0, 0, 0, 3'd2, 4, 0);
        add(0, 0, 0, 3'd3, 2, 1);
        add(0, 0, 0, 3'd4, 5, 1);
        add(0, 0, 0, 3'd5, 5, 1);
        add(0, 0, 0, 3'd0, 1, 1);
        add(0, 0, 0, 3'd0, 2, 0);
        run_tab("stop");

        // night mode raised in R2G, flash, then back to R1Y
        add(1, 0, 0, 3'd1, 5, 0);
        add(1, 0, 0, 3'd2, 5, 1);
        add(1, 0, 0, 3'd3, 2, 1);
        add(1, 0, 0, 3'd4, 2, 1);
        add(1, 0, 1, 3'd4, 3, 0);
        add(0, 0, 1, 3'd6, 1, 1, 1);
        add(0, 1, 1, 3'd6, 3, 0, 1);
        add(0, 1, 1, 3'd6, 4, 0, 0);
        add(0, 0, 1, 3'd6, 2, 0, 1);
        add(0, 0, 0, 3'd1, 1, 0);
        add(1, 0, 0, 3'd1, 4, 0);
        add(1, 0, 0, 3'd2, 5, 1);
        add(1, 0, 0, 3'd3, 1, 1);
        run_tab("night");

        // asynchronous reset in the middle of BOTHY
        #2 rst_n = 1'b0;
        #1;
        check("async_rst", 0, obs1, mk(3'd0, 1'b0, 1'b1));
        @(posedge clk);
        #1;
        check("rst_held", 0, obs1, mk(3'd0, 1'b0, 1'b1));
        en = 1'b0;
        #2 rst_n = 1'b1;
        add(0, 0, 0, 3'd0, 2, 0);
        add(0, 0, 1, 3'd6, 1, 0, 1);
        add(0, 0, 0, 3'd1, 2, 0);
        run_tab("post_rst");

        // short R1G and BOTHY give back-to-back phase_done
        #1;
        check("short_rst", 0, obs2, mk(3'd0, 1'b0, 1'b1));
        ph_s = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
        pd_s = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        rst2_n = 1'b1;
        en2    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sb2.push_back(mk(ph_s[i], pd_s[i], 1'b1));
            @(posedge clk);
            #1;
            check("short", i, obs2, sb2.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_gen.md
# traffic_ctrl_gen

Parametrised two-road traffic controller with on-chip phase timing. It replaces the fixed-table controller that relied on an external 0–23 counter. Phase durations are parameters, `hold` freezes timing, and a night-flash mode is added. Its outputs drive the road and pedestrian lamp drivers directly and report the phase to the supervisory logic.

## Interface
- `CNT_W`, 6: phase timer width; every `T_*` must be ≤ 2^CNT_W.
- `T_Y1`, 5: cycles in R1Y (road1 yellow, pre-green).
- `T_G1`, 5: cycles in R1G.
- `T_YY`, 2: cycles in BOTHY.
- `T_G2`, 5: cycles in R2G.
- `T_Y2`, 5: cycles in R2Y.
- `FLASH_HALF`, 4: cycles per half-period of the flash in FLASH; must be ≥ 1.
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: start / continue cycling.
- `hold`, in, 1: freezes the timer and state in timed states.
- `night_mode`, in, 1: request flashing-yellow operation.
- `enable_sig`, out, 1: controller active (all states except IDLE).
- `road1_out`, `road2_out`, out, 3: lamps {GREEN, YELLOW, RED}, one-hot; 000 means off.
- `ped1`, `ped2`, out, 3: pedestrian lamps, same encoding.
- `phase`, out, 3: IDLE=0, R1Y=1, R1G=2, BOTHY=3, R2G=4, R2Y=5, FLASH=6.
- `phase_done`, out, 1: registered one-cycle pulse on every state change out of a timed state.

## Operation
- One-hot state register. All lamp, `enable_sig` and `phase` outputs are a combinational Moore decode of state (plus the flash bit in FLASH).
- Lamp decode:
  - IDLE: all RED.
  - R1Y: r1 Y, r2 R, p1 R, p2 G.
  - R1G: r1 G, r2 R, p1 R, p2 G.
  - BOTHY: r1 Y, r2 Y, p1 R, p2 R.
  - R2G: r1 R, r2 G, p1 G, p2 R.
  - R2Y: r1 R, r2 Y, p1 G, p2 R.
  - FLASH: r1 and r2 = YELLOW when flash bit = 1, else 000; p1 and p2 = RED.
- Timed states R1Y, R1G, BOTHY, R2G and R2Y use a timer that counts 0..T−1. At the "boundary" (timer == T−1 and `hold` == 0) the state advances and the timer clears.
- Normal sequence: R1Y → R1G → BOTHY → R2G → R2Y → R1Y.
- Boundary priority, evaluated at every boundary:
  1. `night_mode` = 1 → FLASH.
  2. Otherwise, in R2Y only, `enable` = 0 → IDLE.
  3. Otherwise, the next state in the normal sequence.
- `enable` deasserted mid-cycle takes effect only at the end of R2Y, so a full cycle always completes.
- IDLE: `night_mode` = 1 → FLASH; else `enable` = 1 → R1Y with timer 0; else stay.
- FLASH:
  - The flash counter toggles the flash bit every FLASH_HALF cycles. The flash bit is 1 on entry.
  - `hold` does not affect FLASH.
  - `night_mode` = 0 → R1Y with timer 0 on the next edge, regardless of `enable`.
- `hold` = 1 freezes the timer and state, and suppresses the boundary even when timer == T−1.
- `phase_done` asserts the cycle after a timed-state boundary, i.e. coincident with the new state's first cycle.

## Timing
- Reset values:
  - State IDLE, timer 0, flash counter 0, flash bit 1.
  - `phase_done` = 0, `enable_sig` = 0, `phase` = 0.
  - All lamp outputs = RED (001).
- Asserting `rst_n` low in any state returns all outputs to the reset values immediately (asynchronously).
- Latency: an input sampled at edge k produces the new outputs after edge k, i.e. one cycle of latency.
- Cycles per state with `hold` = 0 equal T exactly. With T = 1 the state lasts one cycle.
- With default parameters one full cycle is 22 clocks.

## Structure
- Shared package `traffic_pkg` holds:
  - Lamp constants: RED = 3'b001, YELLOW = 3'b010, GREEN = 3'b100, OFF = 3'b000.
  - One-hot state constants (7-bit).
  - Phase index constants.
- Sub-module `phase_timer` (CNT_W):
  - Inputs `clr`, `hold`, `term` (T−1).
  - Output `done` = (count == `term`) & !`hold`.
- Parameter range checks are done at elaboration.

## Test plan
- Reset, then `enable` = 1 at cycle 0: `enable_sig` rises after the first edge, and phases run with lengths 5/5/2/5/5. `phase_done` pulses once per phase. `phase` sequence is 1,2,3,4,5,1.
- `hold` = 1 for 3 cycles at timer = 4 in R1G: R1G lasts 8 cycles and `phase_done` is delayed by 3.
- `enable` dropped during R1G: the cycle completes through R2Y, then IDLE is entered with all lamps RED and `enable_sig` = 0.
- `night_mode` = 1 during R2G:
  - FLASH is entered at the R2G boundary.
  - Roads show YELLOW for 4 cycles, then 000 for 4 cycles; peds stay RED.
  - After `night_mode` is cleared: R1Y on the next edge.
- `rst_n` pulsed low mid-BOTHY: all outputs are reset values during reset, and IDLE follows.
- Parameters T_G1 = 1, T_YY = 1: R1G and BOTHY each last exactly 1 cycle, and `phase_done` is asserted on consecutive cycles.
